lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter: XLEN, 32, data/address width in bits.
REQ-002 SHALL have port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: req_valid  input  1  datapath presents a load/store request.
REQ-005 SHALL have port: req_ready  output  1  LSU can accept a request.
REQ-006 SHALL have port: req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port: req_funct3  input  3  RISC-V width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have port: req_addr  input  XLEN  byte address.
REQ-009 SHALL have port: req_wdata  input  XLEN  store data, right-aligned.
REQ-010 SHALL have port: resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port: resp_rdata  output  XLEN  extended load result.
REQ-012 SHALL have port: resp_err  output  1  misaligned or illegal request; qualified by resp_valid.
REQ-013 SHALL have port: mem_addr  output  XLEN  word-aligned address to data memory.
REQ-014 SHALL have port: mem_wdata  output  XLEN  full-word write data to data memory.
REQ-015 SHALL have port: mem_we  output  1  data memory write enable.
REQ-016 SHALL have port: mem_rdata  input  XLEN  data memory read word, valid the cycle after a read address is presented with mem_we=0.

Function
REQ-017 SHALL implement states IDLE, RD, CAP, WR, RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 SHALL accept a request on a rising edge where req_valid & req_ready, latching req_we, req_funct3, req_addr, req_wdata; unaccepted inputs SHALL be ignored.
REQ-019 SHALL treat as error: funct3 in {011,110,111}; store with funct3[2]=1; H/HU/SH with addr[0]=1; W with addr[1:0]!=00.
REQ-020 Error request SHALL go IDLE->RESP without any memory access; resp_err=1, resp_rdata=0.
REQ-021 Load SHALL go IDLE->RD->CAP->RESP->IDLE; resp_valid high in the cycle after the 3rd edge counting the accept edge (accept edge E0, pulse between E2 and E3).
REQ-022 SW SHALL go IDLE->WR->RESP->IDLE; mem_we=1 and mem_wdata=latched data for exactly the WR cycle.
REQ-023 SB/SH SHALL go IDLE->RD->CAP->WR->RESP->IDLE (read-modify-write); CAP registers merged word; WR drives it with mem_we=1 for exactly one cycle.
REQ-024 Byte lanes SHALL be little-endian: byte k = bits [8k+7:8k], k=addr[1:0]; halfword at bits [16*addr[1]+15:16*addr[1]].
REQ-025 B/H loads SHALL sign-extend; BU/HU SHALL zero-extend; W SHALL pass through.
REQ-026 Merge SHALL replace only addressed byte/halfword lanes with req_wdata[7:0]/[15:0]; other lanes SHALL retain mem_rdata.
REQ-027 mem_addr SHALL be {latched addr[XLEN-1:2], 2'b00} in RD, CAP, WR; mem_we SHALL be 0 in every state except WR.
REQ-028 resp_rdata and resp_err SHALL hold their values until the next resp_valid; resp_err=0 for successful accesses; stores SHALL return resp_rdata=0.
REQ-029 Back-to-back: a request held valid during RESP SHALL be accepted on the edge after returning to IDLE, never earlier.

Reset
REQ-030 On rst_n low, asynchronously: state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_addr=0, mem_wdata=0, mem_we=0.
REQ-031 Reset mid-operation SHALL abort the request with no response; a store aborted before its WR edge SHALL never assert mem_we.
REQ-032 After rst_n deasserts, first request SHALL be acceptable on the first rising edge.

Verification
REQ-033 Word 0x10=0x8BADF00D; LB 0x13 -> resp_rdata 0xFFFFFF8B; LBU 0x13 -> 0x0000008B; resp_valid between E2 and E3.
REQ-034 Word 0x10=0x11223344; SB 0x11 data 0x000000AA -> mem_wdata 0x1122AA44, mem_we one cycle, then LW 0x10 returns 0x1122AA44.
REQ-035 SW 0x20 0xDEADBEEF -> mem_we only in cycle after E0, resp_valid after E1; LHU 0x22 -> 0x0000DEAD; LH 0x20 -> 0xFFFFBEEF.
REQ-036 LH 0x21 and SW 0x22 -> resp_err=1, resp_rdata=0, mem_we never 1, resp_valid after E0.
REQ-037 SH 0x30 with rst_n pulsed low during CAP -> mem_we stays 0, no resp_valid, req_ready=1 immediately.
REQ-038 req_valid held high with 4 queued loads -> each accepted only when req_ready=1, exactly 4 resp_valid pulses, results in order.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: turns byte/half/word load-store requests into word-wide
// accesses on a synchronous data memory (read data valid one cycle after the
// address). Sub-word stores are done as read-modify-write.
//
// Handshake: a request transfers on a rising edge where req_valid & req_ready.
// req_ready is high only in IDLE. Every accepted request produces exactly one
// single-cycle resp_valid pulse (unless reset intervenes). resp_rdata and
// resp_err are qualified by resp_valid and hold until the next pulse.
module lsu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_we,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [2:0]      dbg_state
);

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t          state;
    logic            we_q;
    logic [2:0]      funct3_q;
    logic [1:0]      off_q;
    logic [15:0]     wdata_q;

    logic            req_bad;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic [XLEN-1:0] load_v;
    logic [4:0]      shamt;
    logic [XLEN-1:0] lane_mask;
    logic [XLEN-1:0] lane_data;
    logic [XLEN-1:0] merged;

    assign dbg_state = state;

    // Classify the incoming request: illegal width codes, unsigned stores and
    // misaligned halfword/word accesses are all reported as errors.
    always_comb begin
        req_bad = 1'b0;
        case (req_funct3)
            F_B:     req_bad = 1'b0;
            F_BU:    req_bad = req_we;
            F_H:     req_bad = req_addr[0];
            F_HU:    req_bad = req_we | req_addr[0];
            F_W:     req_bad = (req_addr[1:0] != 2'b00);
            default: req_bad = 1'b1;
        endcase
    end

    // Pick the addressed little-endian lane out of the read word and extend it.
    always_comb begin
        byte_v = 8'h00;
        case (off_q)
            2'd0:    byte_v = mem_rdata[7:0];
            2'd1:    byte_v = mem_rdata[15:8];
            2'd2:    byte_v = mem_rdata[23:16];
            default: byte_v = mem_rdata[31:24];
        endcase
        half_v = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            F_B:     load_v = {{(XLEN-8){byte_v[7]}}, byte_v};
            F_BU:    load_v = {{(XLEN-8){1'b0}}, byte_v};
            F_H:     load_v = {{(XLEN-16){half_v[15]}}, half_v};
            F_HU:    load_v = {{(XLEN-16){1'b0}}, half_v};
            default: load_v = mem_rdata;
        endcase
    end

    // Build the read-modify-write word: only the addressed lane takes store data.
    always_comb begin
        shamt = {off_q, 3'b000};
        if (funct3_q == F_B) begin
            lane_mask = XLEN'(8'hFF) << shamt;
            lane_data = XLEN'(wdata_q[7:0]) << shamt;
        end else begin
            lane_mask = XLEN'(16'hFFFF) << shamt;
            lane_data = XLEN'(wdata_q) << shamt;
        end
        merged = (mem_rdata & ~lane_mask) | lane_data;
    end

    // Control FSM with all handshake and memory outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            we_q       <= 1'b0;
            funct3_q   <= 3'b000;
            off_q      <= 2'b00;
            wdata_q    <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        funct3_q  <= req_funct3;
                        off_q     <= req_addr[1:0];
                        wdata_q   <= req_wdata[15:0];
                        req_ready <= 1'b0;
                        mem_addr  <= {req_addr[XLEN-1:2], 2'b00};
                        if (req_bad) begin
                            // Errors skip memory entirely.
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (req_we && req_funct3 == F_W) begin
                            // Full-word store needs no read.
                            state     <= WR;
                            mem_wdata <= req_wdata;
                            mem_we    <= 1'b1;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    state <= CAP;
                end
                CAP: begin
                    if (we_q) begin
                        state     <= WR;
                        mem_wdata <= merged;
                        mem_we    <= 1'b1;
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= load_v;
                    end
                end
                WR: begin
                    state      <= RESP;
                    mem_we     <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    mem_we     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed testbench for the load/store unit with a small synchronous memory.
module tb_lsu;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic [2:0]  dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;

    // results of the most recent run_op
    logic [31:0] r_rdata;
    logic        r_err;
    int          r_lat;
    int          r_wcnt;
    int          r_wat;
    logic [31:0] r_wdata;
    logic [31:0] r_addr1;

    logic [31:0] exp_q[$];

    lsu #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous data memory, read data one cycle after the address
    logic [31:0] mem [0:63];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[7:2]];
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "timeout");
    end

    // driver: issue one request and observe the operation up to its response
    task automatic run_op(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd);
        bit got;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        got = 1'b0;
        r_lat = 0; r_wcnt = 0; r_wat = 0; r_wdata = '0;
        r_rdata = 'x; r_err = 1'bx; r_addr1 = '0;
        for (int i = 1; i <= 8 && !got; i++) begin
            @(negedge clk);
            if (i == 1) r_addr1 = mem_addr;
            if (mem_we) begin
                r_wcnt++;
                r_wat   = i;
                r_wdata = mem_wdata;
            end
            if (resp_valid) begin
                got     = 1'b1;
                r_lat   = i;
                r_rdata = resp_rdata;
                r_err   = resp_err;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
        n_cmp++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL rst_resp_err: got %b want 0", resp_err); end
        n_cmp++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_resp_rdata: got %h want 0", resp_rdata); end
        n_cmp++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
        n_cmp++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
        n_cmp++; if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
        rst_n = 1'b1;
    endtask

    task automatic test_load_ext();
        run_op(1'b1, F_W, 32'h10, 32'h8BADF00D);
        n_cmp++; if (r_err !== 1'b0 || r_rdata !== 32'h0 || r_lat != 2 || r_wcnt != 1 || r_wat != 1 || r_wdata !== 32'h8BADF00D)
            begin n_fail++; $display("FAIL sw_10: got err=%b rdata=%h lat=%0d we=%0d@%0d wdata=%h want err=0 rdata=0 lat=2 we=1@1 wdata=8badf00d", r_err, r_rdata, r_lat, r_wcnt, r_wat, r_wdata); end
        run_op(1'b0, F_B, 32'h13, 32'h0);
        n_cmp++; if (r_err !== 1'b0 || r_rdata !== 32'hFFFFFF8B || r_lat != 3 || r_wcnt != 0)
            begin n_fail++; $display("FAIL lb_13: got err=%b rdata=%h lat=%0d we=%0d want err=0 rdata=ffffff8b lat=3 we=0", r_err, r_rdata, r_lat, r_wcnt); end
        run_op(1'b0, F_BU, 32'h13, 32'h0);
        n_cmp++; if (r_err !== 1'b0 || r_rdata !== 32'h0000008B || r_lat != 3)
            begin n_fail++; $display("FAIL lbu_13: got err=%b rdata=%h lat=%0d want err=0 rdata=0000008b lat=3", r_err, r_rdata, r_lat); end
        run_op(1'b0, F_H, 32'h12, 32'h0);
        n_cmp++; if (r_rdata !== 32'hFFFF8BAD) begin n_fail++; $display("FAIL lh_12: got %h want ffff8bad", r_rdata); end
        run_op(1'b0, F_HU, 32'h10, 32'h0);
        n_cmp++; if (r_rdata !== 32'h0000F00D) begin n_fail++; $display("FAIL lhu_10: got %h want 0000f00d", r_rdata); end
        run_op(1'b0, F_B, 32'h10, 32'h0);
        n_cmp++; if (r_rdata !== 32'h0000000D) begin n_fail++; $display("FAIL lb_10: got %h want 0000000d", r_rdata); end
        run_op(1'b0, F_B, 32'h11, 32'h0);
        n_cmp++; if (r_rdata !== 32'hFFFFFFF0) begin n_fail++; $display("FAIL lb_11: got %h want fffffff0", r_rdata); end
        run_op(1'b0, F_W, 32'h10, 32'h0);
        n_cmp++; if (r_rdata !== 32'h8BADF00D || r_lat != 3) begin n_fail++; $display("FAIL lw_10: got %h lat=%0d want 8badf00d lat=3", r_rdata, r_lat); end
    endtask

    task automatic test_rmw();
        run_op(1'b1, F_W, 32'h10, 32'h11223344);
        run_op(1'b1, F_B, 32'h11, 32'h000000AA);
        n_cmp++; if (r_err !== 1'b0 || r_rdata !== 32'h0 || r_lat != 4 || r_wcnt != 1 || r_wat != 3 || r_wdata !== 32'h1122AA44)
            begin n_fail++; $display("FAIL sb_11: got err=%b rdata=%h lat=%0d we=%0d@%0d wdata=%h want err=0 rdata=0 lat=4 we=1@3 wdata=1122aa44", r_err, r_rdata, r_lat, r_wcnt, r_wat, r_wdata); end
        n_cmp++; if (r_addr1 !== 32'h10) begin n_fail++; $display("FAIL sb_11_addr: got %h want 00000010", r_addr1); end
        run_op(1'b0, F_W, 32'h10, 32'h0);
        n_cmp++; if (r_rdata !== 32'h1122AA44) begin n_fail++; $display("FAIL lw_after_sb: got %h want 1122aa44", r_rdata); end
        run_op(1'b1, F_H, 32'h12, 32'h1234BEEF);
        n_cmp++; if (r_wdata !== 32'hBEEFAA44 || r_wcnt != 1 || r_lat != 4)
            begin n_fail++; $display("FAIL sh_12: got wdata=%h we=%0d lat=%0d want beefaa44 we=1 lat=4", r_wdata, r_wcnt, r_lat); end
        run_op(1'b1, F_B, 32'h13, 32'hFFFFFF01);
        n_cmp++; if (r_wdata !== 32'h01EFAA44) begin n_fail++; $display("FAIL sb_13: got %h want 01efaa44", r_wdata); end
        run_op(1'b0, F_W, 32'h10, 32'h0);
        n_cmp++; if (r_rdata !== 32'h01EFAA44) begin n_fail++; $display("FAIL lw_after_rmw: got %h want 01efaa44", r_rdata); end
    endtask

    task automatic test_sw_lh();
        run_op(1'b1, F_W, 32'h20, 32'hDEADBEEF);
        n_cmp++; if (r_lat != 2 || r_wcnt != 1 || r_wat != 1 || r_wdata !== 32'hDEADBEEF || r_addr1 !== 32'h20)
            begin n_fail++; $display("FAIL sw_20: got lat=%0d we=%0d@%0d wdata=%h addr=%h want lat=2 we=1@1 wdata=deadbeef addr=20", r_lat, r_wcnt, r_wat, r_wdata, r_addr1); end
        run_op(1'b0, F_HU, 32'h22, 32'h0);
        n_cmp++; if (r_rdata !== 32'h0000DEAD || r_addr1 !== 32'h20)
            begin n_fail++; $display("FAIL lhu_22: got rdata=%h addr=%h want 0000dead addr=20", r_rdata, r_addr1); end
        run_op(1'b0, F_H, 32'h20, 32'h0);
        n_cmp++; if (r_rdata !== 32'hFFFFBEEF) begin n_fail++; $display("FAIL lh_20: got %h want ffffbeef", r_rdata); end
    endtask

    task automatic test_errors();
        run_op(1'b0, F_H, 32'h21, 32'h0);
        n_cmp++; if (r_err !== 1'b1 || r_rdata !== 32'h0 || r_lat != 1 || r_wcnt != 0)
            begin n_fail++; $display("FAIL err_lh_21: got err=%b rdata=%h lat=%0d we=%0d want err=1 rdata=0 lat=1 we=0", r_err, r_rdata, r_lat, r_wcnt); end
        run_op(1'b1, F_W, 32'h22, 32'h12345678);
        n_cmp++; if (r_err !== 1'b1 || r_rdata !== 32'h0 || r_lat != 1 || r_wcnt != 0)
            begin n_fail++; $display("FAIL err_sw_22: got err=%b rdata=%h lat=%0d we=%0d want err=1 rdata=0 lat=1 we=0", r_err, r_rdata, r_lat, r_wcnt); end
        run_op(1'b0, 3'b011, 32'h10, 32'h0);
        n_cmp++; if (r_err !== 1'b1 || r_lat != 1) begin n_fail++; $display("FAIL err_f3_011: got err=%b lat=%0d want err=1 lat=1", r_err, r_lat); end
        run_op(1'b1, F_BU, 32'h10, 32'h000000FF);
        n_cmp++; if (r_err !== 1'b1 || r_lat != 1 || r_wcnt != 0)
            begin n_fail++; $display("FAIL err_store_bu: got err=%b lat=%0d we=%0d want err=1 lat=1 we=0", r_err, r_lat, r_wcnt); end
        // response fields hold after the pulse
        repeat (2) @(negedge clk);
        n_cmp++; if (resp_err !== 1'b1 || resp_valid !== 1'b0)
            begin n_fail++; $display("FAIL err_hold: got err=%b valid=%b want err=1 valid=0", resp_err, resp_valid); end
        run_op(1'b0, F_B, 32'h10, 32'h0);
        n_cmp++; if (r_err !== 1'b0 || r_rdata !== 32'h00000044)
            begin n_fail++; $display("FAIL ok_after_err: got err=%b rdata=%h want err=0 rdata=00000044", r_err, r_rdata); end
    endtask

    task automatic test_reset_mid();
        int wcnt;
        int rcnt;
        bit got;
        wcnt = 0; rcnt = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F_H;
        req_addr = 32'h30; req_wdata = 32'h00005555;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);                 // RD
        if (mem_we) wcnt++;
        @(negedge clk);                 // CAP
        if (mem_we) wcnt++;
        n_cmp++; if (dbg_state !== 3'd2) begin n_fail++; $display("FAIL mid_in_cap: got state %0d want 2", dbg_state); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 1'b1 || mem_we !== 1'b0 || resp_valid !== 1'b0 || dbg_state !== 3'd0)
            begin n_fail++; $display("FAIL mid_async: got ready=%b we=%b valid=%b state=%0d want 1 0 0 0", req_ready, mem_we, resp_valid, dbg_state); end
        @(negedge clk);
        if (mem_we) wcnt++;
        if (resp_valid) rcnt++;
        // release and present a load in the same instant: first edge accepts it
        rst_n = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = F_W;
        req_addr = 32'h10; req_wdata = 32'h0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n_cmp++; if (dbg_state !== 3'd1 || req_ready !== 1'b0)
            begin n_fail++; $display("FAIL first_edge_accept: got state=%0d ready=%b want 1 0", dbg_state, req_ready); end
        got = 1'b0;
        for (int i = 1; i <= 8 && !got; i++) begin
            @(negedge clk);
            if (mem_we) wcnt++;
            if (resp_valid) begin
                got = 1'b1;
                rcnt++;
                n_cmp++; if (resp_rdata !== 32'h01EFAA44 || i != 3)
                    begin n_fail++; $display("FAIL lw_after_reset: got %h at %0d want 01efaa44 at 3", resp_rdata, i); end
            end
        end
        n_cmp++; if (wcnt != 0 || rcnt != 1)
            begin n_fail++; $display("FAIL mid_abort: got we=%0d resp=%0d want we=0 resp=1", wcnt, rcnt); end
    endtask

    task automatic test_back_to_back();
        logic        q_we    [4];
        logic [2:0]  q_f3    [4];
        logic [31:0] q_addr  [4];
        int          acc_cyc [4];
        int          idx;
        int          nresp;
        logic        rdy;
        logic [31:0] exp_v;
        q_f3[0] = F_W;  q_addr[0] = 32'h10; exp_q.push_back(32'h01EFAA44);
        q_f3[1] = F_HU; q_addr[1] = 32'h22; exp_q.push_back(32'h0000DEAD);
        q_f3[2] = F_B;  q_addr[2] = 32'h13; exp_q.push_back(32'h00000001);
        q_f3[3] = F_W;  q_addr[3] = 32'h20; exp_q.push_back(32'hDEADBEEF);
        for (int k = 0; k < 4; k++) begin q_we[k] = 1'b0; acc_cyc[k] = -1; end
        idx = 0; nresp = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = q_we[0]; req_funct3 = q_f3[0];
        req_addr = q_addr[0]; req_wdata = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            rdy = req_ready;
            @(posedge clk);
            #1;
            if (rdy && req_valid && idx < 4) begin
                acc_cyc[idx] = cyc;
                idx++;
                if (idx < 4) begin
                    req_we = q_we[idx]; req_funct3 = q_f3[idx]; req_addr = q_addr[idx];
                end else begin
                    req_valid = 1'b0;
                end
            end
            @(negedge clk);
            if (resp_valid) begin
                nresp++;
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXXXXXX;
                n_cmp++; if (resp_rdata !== exp_v || resp_err !== 1'b0)
                    begin n_fail++; $display("FAIL b2b_resp%0d: got %h err=%b want %h err=0", nresp, resp_rdata, resp_err, exp_v); end
            end
        end
        req_valid = 1'b0;
        n_cmp++; if (nresp != 4) begin n_fail++; $display("FAIL b2b_count: got %0d want 4", nresp); end
        n_cmp++; if (acc_cyc[0] != 0 || acc_cyc[1] != 4 || acc_cyc[2] != 8 || acc_cyc[3] != 12)
            begin n_fail++; $display("FAIL b2b_accept: got %0d %0d %0d %0d want 0 4 8 12", acc_cyc[0], acc_cyc[1], acc_cyc[2], acc_cyc[3]); end
    endtask

    initial begin
        test_reset();
        test_load_ext();
        test_rmw();
        test_sw_lh();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
